// File: rtl/pipe_em_skid.sv
// Execute->Memory pipeline stage with a valid/ready handshake on both sides
// and a two-entry skid buffer. ready_e is decoded only from the state
// register, so Memory backpressure (ready_m) never reaches Execute
// combinationally. Also provides flush, control gating and a stall counter.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A producer keeps valid and its payload steady until the
// transfer. ready never depends combinationally on the partner's valid.
module pipe_em_skid #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int RSRC_WIDTH  = 2,
    parameter int MEMOP_WIDTH = 3,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    // Execute side
    input  logic                   valid_e,
    output logic                   ready_e,
    input  logic                   RegWriteE,
    input  logic [RSRC_WIDTH-1:0]  ResultSrcE,
    input  logic                   MemWriteE,
    input  logic [MEMOP_WIDTH-1:0] MemoryOpE,
    input  logic [DATA_WIDTH-1:0]  ALUResultE,
    input  logic [DATA_WIDTH-1:0]  WriteDataE,
    input  logic [ADDR_WIDTH-1:0]  RdE,
    input  logic [DATA_WIDTH-1:0]  PCPlus4E,
    // Memory side
    output logic                   valid_m,
    input  logic                   ready_m,
    output logic                   RegWriteM,
    output logic [RSRC_WIDTH-1:0]  ResultSrcM,
    output logic                   MemWriteM,
    output logic [MEMOP_WIDTH-1:0] MemoryOpM,
    output logic [DATA_WIDTH-1:0]  ALUResultM,
    output logic [DATA_WIDTH-1:0]  WriteDataM,
    output logic [ADDR_WIDTH-1:0]  RdM,
    output logic [DATA_WIDTH-1:0]  PCPlus4M,
    // Status
    output logic [CNT_WIDTH-1:0]   stall_cnt,
    output logic [1:0]             o_dbg_state
);

    localparam int PW = 2 + RSRC_WIDTH + MEMOP_WIDTH + 3 * DATA_WIDTH + ADDR_WIDTH;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [PW-1:0]          r_main;
    logic [PW-1:0]          r_skid;
    logic [PW-1:0]          w_pay_e;
    logic [CNT_WIDTH-1:0]   r_stall_cnt;
    logic                   w_in_fire;
    logic                   w_out_fire;
    logic                   w_load_main_e;
    logic                   w_load_main_skid;
    logic                   w_load_skid;
    logic                   w_reg_write;
    logic                   w_mem_write;

    assign w_pay_e = {RegWriteE, ResultSrcE, MemWriteE, MemoryOpE,
                      ALUResultE, WriteDataE, RdE, PCPlus4E};

    assign ready_e    = (r_state != TWO);
    assign valid_m    = (r_state != EMPTY);
    assign w_in_fire  = valid_e & ready_e & ~flush;
    assign w_out_fire = valid_m & ready_m;

    // Next-state and payload-load decode; flush overrides every handshake move
    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_e    = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_in_fire) begin
                    w_state_nxt   = ONE;
                    w_load_main_e = 1'b1;
                end
            end
            ONE: begin
                if (w_in_fire && w_out_fire) begin
                    w_load_main_e = 1'b1;
                end else if (w_in_fire) begin
                    w_state_nxt = TWO;
                    w_load_skid = 1'b1;
                end else if (w_out_fire) begin
                    w_state_nxt = EMPTY;
                end
            end
            TWO: begin
                if (w_out_fire) begin
                    w_state_nxt      = ONE;
                    w_load_main_skid = 1'b1;
                end
            end
            default: w_state_nxt = EMPTY;
        endcase
        if (flush) begin
            w_state_nxt      = EMPTY;
            w_load_main_skid = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Head and skid payload registers; head refills from skid to keep FIFO order
    always_ff @(posedge clk) begin
        if (rst) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_main_e) begin
                r_main <= w_pay_e;
            end else if (w_load_main_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_pay_e;
            end
        end
    end

    // Saturating count of cycles where Memory holds off a valid head entry
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (valid_m && !ready_m && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
        end
    end

    assign {w_reg_write, ResultSrcM, w_mem_write, MemoryOpM,
            ALUResultM, WriteDataM, RdM, PCPlus4M} = r_main;

    // Bubbles must never write the register file or memory
    assign RegWriteM   = w_reg_write & valid_m;
    assign MemWriteM   = w_mem_write & valid_m;
    assign stall_cnt   = r_stall_cnt;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pipe_em_skid.sv
// Testbench for pipe_em_skid: directed scenarios plus random traffic,
// checked against a queue-based reference model of the two-entry stage.
module tb_pipe_em_skid;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int RW   = 2;
    localparam int MW   = 3;
    localparam int CW   = 16;
    localparam int PW   = 2 + RW + MW + 3 * DW + AW;
    localparam int CMAX = (1 << CW) - 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          valid_e = 1'b0;
    logic          ready_e;
    logic          RegWriteE = 1'b0;
    logic [RW-1:0] ResultSrcE = '0;
    logic          MemWriteE = 1'b0;
    logic [MW-1:0] MemoryOpE = '0;
    logic [DW-1:0] ALUResultE = '0;
    logic [DW-1:0] WriteDataE = '0;
    logic [AW-1:0] RdE = '0;
    logic [DW-1:0] PCPlus4E = '0;
    logic          valid_m;
    logic          ready_m = 1'b0;
    logic          RegWriteM;
    logic [RW-1:0] ResultSrcM;
    logic          MemWriteM;
    logic [MW-1:0] MemoryOpM;
    logic [DW-1:0] ALUResultM;
    logic [DW-1:0] WriteDataM;
    logic [AW-1:0] RdM;
    logic [DW-1:0] PCPlus4M;
    logic [CW-1:0] stall_cnt;
    logic [1:0]    dbg_state;

    pipe_em_skid #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RSRC_WIDTH(RW),
        .MEMOP_WIDTH(MW), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .valid_e(valid_e), .ready_e(ready_e),
        .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
        .MemoryOpE(MemoryOpE), .ALUResultE(ALUResultE), .WriteDataE(WriteDataE),
        .RdE(RdE), .PCPlus4E(PCPlus4E),
        .valid_m(valid_m), .ready_m(ready_m),
        .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
        .MemoryOpM(MemoryOpM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .RdM(RdM), .PCPlus4M(PCPlus4M),
        .stall_cnt(stall_cnt), .o_dbg_state(dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [PW-1:0] exp_q[$];      // entries held by the stage, oldest first
    int exp_stall = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] in_payload();
        return {RegWriteE, ResultSrcE, MemWriteE, MemoryOpE,
                ALUResultE, WriteDataE, RdE, PCPlus4E};
    endfunction

    function automatic logic [PW-1:0] out_payload();
        return {RegWriteM, ResultSrcM, MemWriteM, MemoryOpM,
                ALUResultM, WriteDataM, RdM, PCPlus4M};
    endfunction

    // ---------------- monitor / reference model ----------------
    // Evaluated mid-cycle: inputs and outputs are stable, and the model
    // predicts what the next rising edge does to the held-entry queue.
    always @(negedge clk) begin
        logic do_out;
        logic do_in;
        if (rst) begin
            exp_q.delete();
            exp_stall = 0;
        end else begin
            check("ready_e", ready_e, exp_q.size() < 2);
            check("valid_m", valid_m, exp_q.size() > 0);
            check("stall_cnt", stall_cnt, exp_stall);
            if (exp_q.size() == 0) begin
                check("gate_regwrite", RegWriteM, 1'b0);
                check("gate_memwrite", MemWriteM, 1'b0);
            end
            do_out = (exp_q.size() > 0) && ready_m;
            do_in  = valid_e && (exp_q.size() < 2) && !flush;
            if (do_out) begin
                check("payload_m", out_payload(), exp_q.pop_front());
            end
            if ((exp_q.size() > 0 || do_out) && !ready_m && exp_stall < CMAX) begin
                exp_stall++;
            end
            if (flush) begin
                exp_q.delete();
            end else if (do_in) begin
                exp_q.push_back(in_payload());
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Apply one cycle of stimulus just after the rising edge.
    task automatic drive(input logic v, input logic rm, input logic fl,
                         input logic rs, input logic [DW-1:0] alu);
        valid_e    = v;
        ready_m    = rm;
        flush      = fl;
        rst        = rs;
        ALUResultE = alu;
        RegWriteE  = 1'($urandom_range(0, 1));
        MemWriteE  = 1'($urandom_range(0, 1));
        ResultSrcE = RW'($urandom);
        MemoryOpE  = MW'($urandom);
        WriteDataE = $urandom;
        RdE        = AW'($urandom);
        PCPlus4E   = $urandom;
        @(posedge clk);
        #1;
    endtask

    // Let the monitor finish, then look at outputs mid-cycle
    task automatic mid_cycle();
        @(negedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0);
        // reset state
        check("rst_valid_m", valid_m, 1'b0);
        check("rst_ready_e", ready_e, 1'b1);
        check("rst_alu", ALUResultM, '0);
        check("rst_stall", stall_cnt, '0);

        // 1: streaming, one-cycle latency
        for (int i = 1; i <= 8; i++) drive(1, 1, 0, 0, DW'(i));
        drive(0, 1, 0, 0, 0);
        drive(0, 1, 0, 0, 0);

        // 2: backpressure fills both entries, C held off until drained
        drive(1, 0, 0, 0, 32'hA);
        drive(1, 0, 0, 0, 32'hB);
        valid_e = 1'b1; ALUResultE = 32'hC;
        mid_cycle();
        check("bp_state_two", dbg_state, 2'd2);
        check("bp_ready_e", ready_e, 1'b0);
        @(posedge clk); #1;
        drive(1, 1, 0, 0, 32'hC);
        drive(1, 1, 0, 0, 32'hC);
        drive(0, 1, 0, 0, 0);
        drive(0, 1, 0, 0, 0);

        // 3: flush while full; D offered in the same cycle must vanish
        drive(1, 0, 0, 0, 32'h11);
        drive(1, 0, 0, 0, 32'h22);
        RegWriteE = 1'b1;
        valid_e = 1'b1; flush = 1'b1; ALUResultE = 32'hD;
        @(posedge clk); #1;
        flush = 1'b0; valid_e = 1'b0;
        mid_cycle();
        check("flush_valid_m", valid_m, 1'b0);
        check("flush_regwrite", RegWriteM, 1'b0);
        check("flush_memwrite", MemWriteM, 1'b0);
        check("flush_ready_e", ready_e, 1'b1);

        // 4: bubbles carrying write enables stay gated
        for (int i = 0; i < 3; i++) begin
            valid_e = 1'b0; RegWriteE = 1'b1; MemWriteE = 1'b1; ready_m = 1'b1;
            @(posedge clk); #1;
        end
        check("bubble_regwrite", RegWriteM, 1'b0);
        check("bubble_memwrite", MemWriteM, 1'b0);

        // 5: stall counter saturates
        drive(1, 0, 0, 0, 32'h55);
        for (int i = 0; i < CMAX + 5; i++) drive(0, 0, 0, 0, 0);
        mid_cycle();
        check("stall_saturated", stall_cnt, 16'hFFFF);

        // 6: reset while full, then a normal push
        drive(1, 0, 0, 0, 32'h66);
        check("pre_rst_state_two", dbg_state, 2'd2);
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0);
        check("rst_mid_valid_m", valid_m, 1'b0);
        check("rst_mid_ready_e", ready_e, 1'b1);
        check("rst_mid_alu", ALUResultM, '0);
        check("rst_mid_pc", PCPlus4M, '0);
        check("rst_mid_stall", stall_cnt, '0);
        drive(1, 1, 0, 0, 32'h77);
        drive(0, 1, 0, 0, 0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 199) == 0),
                  $urandom);
        end

        // drain, bounded
        begin
            int budget = 20;
            while (exp_q.size() > 0 && budget > 0) begin
                drive(0, 1, 0, 0, 0);
                budget--;
            end
            check("drain_empty", exp_q.size(), 0);
        end
        drive(0, 1, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
